// File: rtl/viterbi_acs_pmu_if.sv
// Port bundle for the K=3 Viterbi add-compare-select / path-metric unit.
// The branch-metric stage drives the master side; the ACS unit is the slave.
interface viterbi_acs_pmu_if #(
  parameter int PM_W  = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             in_valid;
  logic [1:0]       bm_00;
  logic [1:0]       bm_01;
  logic [1:0]       bm_10;
  logic [1:0]       bm_11;
  logic             dec_valid;
  logic [3:0]       dec;
  logic [PM_W-1:0]  pm0;
  logic [PM_W-1:0]  pm1;
  logic [PM_W-1:0]  pm2;
  logic [PM_W-1:0]  pm3;
  logic [1:0]       best_state;
  logic [PM_W-1:0]  best_metric;
  logic [CNT_W-1:0] sym_cnt;

  modport master (
    output start, in_valid, bm_00, bm_01, bm_10, bm_11,
    input  dec_valid, dec, pm0, pm1, pm2, pm3, best_state, best_metric, sym_cnt
  );

  modport slave (
    input  start, in_valid, bm_00, bm_01, bm_10, bm_11,
    output dec_valid, dec, pm0, pm1, pm2, pm3, best_state, best_metric, sym_cnt
  );
endinterface

// File: rtl/viterbi_acs_pmu.sv
// Add-compare-select and path-metric unit for the rate-1/2, K=3 (4-state)
// Viterbi decoder: one trellis step per valid symbol, survivor bits out.
module viterbi_acs_pmu #(
  parameter int PM_W    = 8,
  parameter int INIT_PM = 16,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  viterbi_acs_pmu_if.slave bus
);

  localparam logic [PM_W-1:0] INIT_V   = PM_W'(INIT_PM);
  localparam logic [PM_W-1:0] MSB_MASK = {1'b1, {(PM_W-1){1'b0}}};

  function automatic logic [1:0] bm_f(input logic [1:0] code,
                                      input logic [1:0] b00, input logic [1:0] b01,
                                      input logic [1:0] b10, input logic [1:0] b11);
    case (code)
      2'b00:   bm_f = b00;
      2'b01:   bm_f = b01;
      2'b10:   bm_f = b10;
      2'b11:   bm_f = b11;
      default: bm_f = 2'b00;
    endcase
  endfunction

  logic [PM_W-1:0]  pm_q [4];
  logic [PM_W-1:0]  pm_d [4];
  logic [PM_W-1:0]  pm_src_s [4];
  logic [PM_W-1:0]  raw_s [4];
  logic [PM_W:0]    cand0_s [4];
  logic [PM_W:0]    cand1_s [4];
  logic [1:0]       code0_s [4];
  logic [3:0]       msb_s;
  logic             norm_s;
  logic [3:0]       dec_d;
  logic [3:0]       dec_q;
  logic             dec_valid_q;
  logic [1:0]       best_state_d;
  logic [1:0]       best_state_q;
  logic [PM_W-1:0]  best_metric_d;
  logic [PM_W-1:0]  best_metric_q;
  logic [CNT_W-1:0] sym_cnt_q;

  // Predecessor metrics: a start in the same cycle as a symbol uses the frame-initial metrics.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (bus.start) begin
        pm_src_s[i] = (i == 0) ? {PM_W{1'b0}} : INIT_V;
      end else begin
        pm_src_s[i] = pm_q[i];
      end
    end
  end

  // Butterfly per next state ns: predecessors {ns[0],0} and {ns[0],1}; the p1 code is the inverse of the p0 code.
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      code0_s[ns] = {ns[1] ^ ns[0], ns[1]};
      cand0_s[ns] = {1'b0, pm_src_s[{ns[0], 1'b0}]} +
                    {{(PM_W-1){1'b0}}, bm_f(code0_s[ns], bus.bm_00, bus.bm_01, bus.bm_10, bus.bm_11)};
      cand1_s[ns] = {1'b0, pm_src_s[{ns[0], 1'b1}]} +
                    {{(PM_W-1){1'b0}}, bm_f(~code0_s[ns], bus.bm_00, bus.bm_01, bus.bm_10, bus.bm_11)};
      dec_d[ns]   = (cand1_s[ns] < cand0_s[ns]);
      raw_s[ns]   = dec_d[ns] ? cand1_s[ns][PM_W-1:0] : cand0_s[ns][PM_W-1:0];
      msb_s[ns]   = raw_s[ns][PM_W-1];
    end
  end

  // Normalisation: metrics stay within a small spread, so dropping a common MSB is lossless.
  always_comb begin
    norm_s = &msb_s;
    for (int i = 0; i < 4; i++) begin
      if (norm_s) begin
        pm_d[i] = raw_s[i] & ~MSB_MASK;
      end else begin
        pm_d[i] = raw_s[i];
      end
    end
  end

  // Minimum search over the new metrics; strict compare keeps the lowest index on ties.
  always_comb begin
    best_state_d  = 2'd0;
    best_metric_d = pm_d[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_d[i] < best_metric_d) begin
        best_state_d  = 2'(i);
        best_metric_d = pm_d[i];
      end else begin
        best_state_d  = best_state_d;
        best_metric_d = best_metric_d;
      end
    end
  end

  // State registers: symbol update, frame restart, or hold with dec_valid dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i] <= (i == 0) ? {PM_W{1'b0}} : INIT_V;
      end
      dec_q         <= 4'b0000;
      dec_valid_q   <= 1'b0;
      best_state_q  <= 2'd0;
      best_metric_q <= {PM_W{1'b0}};
      sym_cnt_q     <= {CNT_W{1'b0}};
    end else if (bus.in_valid) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i] <= pm_d[i];
      end
      dec_q         <= dec_d;
      dec_valid_q   <= 1'b1;
      best_state_q  <= best_state_d;
      best_metric_q <= best_metric_d;
      sym_cnt_q     <= bus.start ? CNT_W'(1) : sym_cnt_q + CNT_W'(1);
    end else if (bus.start) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i] <= (i == 0) ? {PM_W{1'b0}} : INIT_V;
      end
      dec_q         <= 4'b0000;
      dec_valid_q   <= 1'b0;
      best_state_q  <= 2'd0;
      best_metric_q <= {PM_W{1'b0}};
      sym_cnt_q     <= {CNT_W{1'b0}};
    end else begin
      dec_valid_q   <= 1'b0;
    end
  end

  assign bus.pm0         = pm_q[0];
  assign bus.pm1         = pm_q[1];
  assign bus.pm2         = pm_q[2];
  assign bus.pm3         = pm_q[3];
  assign bus.dec         = dec_q;
  assign bus.dec_valid   = dec_valid_q;
  assign bus.best_state  = best_state_q;
  assign bus.best_metric = best_metric_q;
  assign bus.sym_cnt     = sym_cnt_q;

endmodule

// File: tb/tb_viterbi_acs_pmu.sv
// Directed bench for viterbi_acs_pmu: hand-computed trellis steps for PM_W=8, INIT_PM=16.
module tb_viterbi_acs_pmu;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] pm_all;
  logic [30:0] st_all;

  always #5 clk = ~clk;

  viterbi_acs_pmu_if #(.PM_W(8), .CNT_W(16)) ifc ();

  viterbi_acs_pmu #(.PM_W(8), .INIT_PM(16), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // pm as {pm0,pm1,pm2,pm3}; status as {dec_valid, dec, best_state, best_metric, sym_cnt}
  assign pm_all = {ifc.pm0, ifc.pm1, ifc.pm2, ifc.pm3};
  assign st_all = {ifc.dec_valid, ifc.dec, ifc.best_state, ifc.best_metric, ifc.sym_cnt};

  task automatic sym(input logic [1:0] b00, input logic [1:0] b01,
                     input logic [1:0] b10, input logic [1:0] b11, input logic st);
    ifc.in_valid = 1'b1;
    ifc.start    = st;
    ifc.bm_00 = b00; ifc.bm_01 = b01; ifc.bm_10 = b10; ifc.bm_11 = b11;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.start    = 1'b0;
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
    ifc.bm_00 = 2'd3; ifc.bm_01 = 2'd3; ifc.bm_10 = 2'd3; ifc.bm_11 = 2'd3;
    @(posedge clk); #1;
  endtask

  task automatic clear();
    ifc.start = 1'b1;
    idle();
    ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    ifc.start = 1'b0; ifc.in_valid = 1'b0;
    ifc.bm_00 = 2'd0; ifc.bm_01 = 2'd0; ifc.bm_10 = 2'd0; ifc.bm_11 = 2'd0;
    rst_n = 1'b0;
    #12;
    vectors++;
    if (pm_all !== {8'd0, 8'd16, 8'd16, 8'd16}) begin
      miscompares++; $display("FAIL reset_pm got %h want %h", pm_all, {8'd0, 8'd16, 8'd16, 8'd16});
    end
    vectors++;
    if (st_all !== 31'd0) begin
      miscompares++; $display("FAIL reset_status got %h want %h", st_all, 31'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_symbol();
    sym(2'd0, 2'd1, 2'd1, 2'd2, 1'b0);
    vectors++;
    if (pm_all !== {8'd0, 8'd17, 8'd2, 8'd17}) begin
      miscompares++; $display("FAIL first_pm got %h want %h", pm_all, {8'd0, 8'd17, 8'd2, 8'd17});
    end
    vectors++;
    if (st_all !== {1'b1, 4'b0000, 2'd0, 8'd0, 16'd1}) begin
      miscompares++; $display("FAIL first_status got %h want %h", st_all, {1'b1, 4'b0000, 2'd0, 8'd0, 16'd1});
    end
    idle();
    vectors++;
    if ({pm_all, st_all} !== {8'd0, 8'd17, 8'd2, 8'd17, 1'b0, 4'b0000, 2'd0, 8'd0, 16'd1}) begin
      miscompares++; $display("FAIL first_idle_hold got %h want %h", {pm_all, st_all},
                              {8'd0, 8'd17, 8'd2, 8'd17, 1'b0, 4'b0000, 2'd0, 8'd0, 16'd1});
    end
  endtask

  task automatic test_decision();
    clear();
    sym(2'd2, 2'd2, 2'd2, 2'd2, 1'b0);
    sym(2'd2, 2'd2, 2'd2, 2'd2, 1'b0);
    vectors++;
    if (pm_all !== {8'd4, 8'd4, 8'd4, 8'd4}) begin
      miscompares++; $display("FAIL dec_setup_pm got %h want %h", pm_all, {8'd4, 8'd4, 8'd4, 8'd4});
    end
    sym(2'd2, 2'd0, 2'd0, 2'd2, 1'b0);
    vectors++;
    if ({pm_all, st_all} !== {8'd6, 8'd4, 8'd6, 8'd4, 1'b1, 4'b0000, 2'd1, 8'd4, 16'd3}) begin
      miscompares++; $display("FAIL dec_tie_best got %h want %h", {pm_all, st_all},
                              {8'd6, 8'd4, 8'd6, 8'd4, 1'b1, 4'b0000, 2'd1, 8'd4, 16'd3});
    end
    sym(2'd1, 2'd0, 2'd0, 2'd0, 1'b0);
    vectors++;
    if ({pm_all, st_all} !== {8'd4, 8'd4, 8'd5, 8'd4, 1'b1, 4'b1111, 2'd0, 8'd4, 16'd4}) begin
      miscompares++; $display("FAIL dec_p1_select got %h want %h", {pm_all, st_all},
                              {8'd4, 8'd4, 8'd5, 8'd4, 1'b1, 4'b1111, 2'd0, 8'd4, 16'd4});
    end
    idle();
    vectors++;
    if (st_all !== {1'b0, 4'b1111, 2'd0, 8'd4, 16'd4}) begin
      miscompares++; $display("FAIL dec_hold got %h want %h", st_all, {1'b0, 4'b1111, 2'd0, 8'd4, 16'd4});
    end
  endtask

  task automatic test_start_clear();
    clear();
    vectors++;
    if ({pm_all, st_all} !== {8'd0, 8'd16, 8'd16, 8'd16, 31'd0}) begin
      miscompares++; $display("FAIL start_clear got %h want %h", {pm_all, st_all},
                              {8'd0, 8'd16, 8'd16, 8'd16, 31'd0});
    end
  endtask

  task automatic test_normalise();
    clear();
    for (int k = 1; k <= 64; k++) begin
      sym(2'd2, 2'd2, 2'd2, 2'd2, 1'b0);
      if (k == 2) begin
        vectors++;
        if (pm_all !== {8'd4, 8'd4, 8'd4, 8'd4}) begin
          miscompares++; $display("FAIL norm_k2 got %h want %h", pm_all, {8'd4, 8'd4, 8'd4, 8'd4});
        end
      end else if (k == 63) begin
        vectors++;
        if (pm_all !== {8'd126, 8'd126, 8'd126, 8'd126}) begin
          miscompares++; $display("FAIL norm_k63 got %h want %h", pm_all, {8'd126, 8'd126, 8'd126, 8'd126});
        end
      end else if (k == 64) begin
        vectors++;
        if ({pm_all, st_all} !== {32'd0, 1'b1, 4'b0000, 2'd0, 8'd0, 16'd64}) begin
          miscompares++; $display("FAIL norm_k64 got %h want %h", {pm_all, st_all},
                                  {32'd0, 1'b1, 4'b0000, 2'd0, 8'd0, 16'd64});
        end
      end
    end
  endtask

  task automatic test_gaps();
    int         k;
    logic [7:0] e0;
    logic [7:0] e1;
    clear();
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        sym(2'd2, 2'd2, 2'd2, 2'd2, 1'b0);
        k++;
      end else begin
        idle();
      end
      e0 = 8'(2 * k);
      e1 = (k == 1) ? 8'd18 : 8'(2 * k);
      vectors++;
      if ({pm_all, ifc.dec_valid, ifc.sym_cnt} !== {e0, e1, e0, e1, (i % 2 == 0), 16'(k)}) begin
        miscompares++; $display("FAIL gaps_cycle%0d got %h want %h", i, {pm_all, ifc.dec_valid, ifc.sym_cnt},
                                {e0, e1, e0, e1, (i % 2 == 0), 16'(k)});
      end
    end
  endtask

  task automatic test_start_midframe();
    clear();
    for (int k = 0; k < 20; k++) sym(2'd2, 2'd2, 2'd2, 2'd2, 1'b0);
    vectors++;
    if ({pm_all, ifc.sym_cnt} !== {8'd40, 8'd40, 8'd40, 8'd40, 16'd20}) begin
      miscompares++; $display("FAIL mid_pre got %h want %h", {pm_all, ifc.sym_cnt}, {8'd40, 8'd40, 8'd40, 8'd40, 16'd20});
    end
    sym(2'd0, 2'd1, 2'd1, 2'd2, 1'b1);
    vectors++;
    if ({pm_all, st_all} !== {8'd0, 8'd17, 8'd2, 8'd17, 1'b1, 4'b0000, 2'd0, 8'd0, 16'd1}) begin
      miscompares++; $display("FAIL mid_start got %h want %h", {pm_all, st_all},
                              {8'd0, 8'd17, 8'd2, 8'd17, 1'b1, 4'b0000, 2'd0, 8'd0, 16'd1});
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) sym(2'd2, 2'd2, 2'd2, 2'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pm_all, st_all} !== {8'd0, 8'd16, 8'd16, 8'd16, 31'd0}) begin
      miscompares++; $display("FAIL async_reset got %h want %h", {pm_all, st_all},
                              {8'd0, 8'd16, 8'd16, 8'd16, 31'd0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sym(2'd0, 2'd1, 2'd1, 2'd2, 1'b0);
    vectors++;
    if ({pm_all, st_all} !== {8'd0, 8'd17, 8'd2, 8'd17, 1'b1, 4'b0000, 2'd0, 8'd0, 16'd1}) begin
      miscompares++; $display("FAIL after_reset got %h want %h", {pm_all, st_all},
                              {8'd0, 8'd17, 8'd2, 8'd17, 1'b1, 4'b0000, 2'd0, 8'd0, 16'd1});
    end
  endtask

  initial begin
    test_reset();
    test_first_symbol();
    test_decision();
    test_start_clear();
    test_normalise();
    test_gaps();
    test_start_midframe();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
